// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline stage for shift-class instructions: a two-entry skid buffer
// (MAIN head + SKID) that captures operands, shift amount and legality for the Shift_Unit.
module id_ex_shift_stage #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] Rs1_in,
    input  logic [XLEN-1:0] Rs2_in,
    input  logic [4:0]      imm_shamt,
    input  logic            use_imm,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Rs1,
    output logic [5:0]      Rs2,
    output logic            funct3_2,
    output logic            funct7_5,
    output logic            En,
    output logic [4:0]      rd_out,
    output logic            illegal
);

    // Entry layout: {rs1, shamt[4:0], funct3[2], funct7[5], rd[4:0], legal}
    localparam int EW = XLEN + 13;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [EW-1:0]   main_r;
    logic [EW-1:0]   main_s;
    logic [EW-1:0]   skid_r;
    logic [EW-1:0]   skid_s;
    logic [EW-1:0]   entry_s;
    logic [4:0]      shamt_s;
    logic            push_s;
    logic            pop_s;
    logic            unused_s;

    function automatic logic legal_enc(input logic [2:0] f3, input logic [6:0] f7);
        legal_enc = ((f3 == 3'b001) && (f7 == 7'b0000000)) ||
                    ((f3 == 3'b101) && (f7 == 7'b0000000)) ||
                    ((f3 == 3'b101) && (f7 == 7'b0100000));
    endfunction

    assign unused_s = ^Rs2_in[XLEN-1:5];

    // Build the entry captured from the decode inputs
    always_comb begin
        shamt_s = use_imm ? imm_shamt : Rs2_in[4:0];
        entry_s = {Rs1_in, shamt_s, funct3[2], funct7[5], rd_in, legal_enc(funct3, funct7)};
    end

    // Handshakes use the registered ready/valid, so out_ready never reaches in_ready combinationally
    always_comb begin
        push_s = in_valid & in_ready;
        pop_s  = out_valid & out_ready;
    end

    // Next-state and next-payload selection for the skid buffer
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = EMPTY;
            main_s  = '0;
            skid_s  = '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        main_s  = entry_s;
                        state_s = ONE;
                    end else begin
                        state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        main_s  = entry_s;
                        state_s = ONE;
                    end else if (push_s) begin
                        skid_s  = entry_s;
                        state_s = FULL;
                    end else if (pop_s) begin
                        main_s  = '0;
                        state_s = EMPTY;
                    end else begin
                        state_s = ONE;
                    end
                end
                FULL: begin
                    if (pop_s) begin
                        main_s  = skid_r;
                        skid_s  = '0;
                        state_s = ONE;
                    end else begin
                        state_s = FULL;
                    end
                end
                default: begin
                    state_s = EMPTY;
                    main_s  = '0;
                    skid_s  = '0;
                end
            endcase
        end
    end

    // State, storage and registered outputs; outputs mirror next MAIN (zeroed when empty)
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r   <= EMPTY;
            main_r    <= '0;
            skid_r    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Rs1       <= '0;
            Rs2       <= 6'b000000;
            funct3_2  <= 1'b0;
            funct7_5  <= 1'b0;
            rd_out    <= 5'b00000;
            En        <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state_r   <= state_s;
            main_r    <= main_s;
            skid_r    <= skid_s;
            in_ready  <= (state_s != FULL);
            out_valid <= (state_s != EMPTY);
            Rs1       <= main_s[EW-1 -: XLEN];
            Rs2       <= {1'b0, main_s[12:8]};
            funct3_2  <= main_s[7];
            funct7_5  <= main_s[6];
            rd_out    <= main_s[5:1];
            En        <= (state_s != EMPTY) & main_s[0];
            illegal   <= (state_s != EMPTY) & ~main_s[0];
        end
    end

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Self-checking bench for id_ex_shift_stage: a queue-based FIFO model of depth two
// predicts every output after each rising edge.
module tb_id_ex_shift_stage;

    localparam int XLEN = 32;

    logic            CLK = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] Rs1_in;
    logic [XLEN-1:0] Rs2_in;
    logic [4:0]      imm_shamt;
    logic            use_imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Rs1;
    logic [5:0]      Rs2;
    logic            funct3_2;
    logic            funct7_5;
    logic            En;
    logic [4:0]      rd_out;
    logic            illegal;

    typedef struct packed {
        logic [31:0] rs1;
        logic [4:0]  sh;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
    } item_t;

    item_t q[$];
    int checks = 0;
    int errors = 0;

    id_ex_shift_stage #(.XLEN(XLEN)) dut (
        .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Rs1_in(Rs1_in), .Rs2_in(Rs2_in), .imm_shamt(imm_shamt), .use_imm(use_imm),
        .funct3(funct3), .funct7(funct7), .rd_in(rd_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .Rs1(Rs1), .Rs2(Rs2),
        .funct3_2(funct3_2), .funct7_5(funct7_5), .En(En), .rd_out(rd_out),
        .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    function automatic logic is_legal(input logic [2:0] f3, input logic [6:0] f7);
        if (f3 == 3'd1) return (f7 == 7'd0);
        if (f3 == 3'd5) return (f7 == 7'd0) || (f7 == 7'd32);
        return 1'b0;
    endfunction

    // {out_valid, in_ready, Rs1, Rs2, funct3_2, funct7_5, En, rd_out, illegal}
    function automatic logic [48:0] model_out();
        item_t h;
        logic  lg;
        if (q.size() == 0) return {1'b0, 1'b1, 47'd0};
        h  = q[0];
        lg = is_legal(h.f3, h.f7);
        return {1'b1, (q.size() < 2), h.rs1, {1'b0, h.sh}, h.f3[2], h.f7[5], lg, h.rd, ~lg};
    endfunction

    function automatic logic [48:0] dut_out();
        return {out_valid, in_ready, Rs1, Rs2, funct3_2, funct7_5, En, rd_out, illegal};
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] imm, input logic ui, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd);
        in_valid = v; Rs1_in = a; Rs2_in = b; imm_shamt = imm;
        use_imm = ui; funct3 = f3; funct7 = f7; rd_in = rd;
    endtask

    task automatic drive_random(input logic v, input logic legal_only);
        logic [2:0] f3;
        logic [6:0] f7;
        if (legal_only) begin
            f3 = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
            f7 = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'd32 : 7'd0;
        end else begin
            f3 = 3'($urandom_range(0, 7));
            f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'd0 : 7'd32);
        end
        drive(v, $urandom, $urandom, 5'($urandom), 1'($urandom), f3, f7, 5'($urandom));
    endtask

    // Advance one edge and update the model from the values presented before it
    task automatic tick();
        logic  push;
        logic  pop;
        item_t it;
        push = in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && out_ready;
        it.rs1 = Rs1_in;
        it.sh  = use_imm ? imm_shamt : Rs2_in[4:0];
        it.f3  = funct3;
        it.f7  = funct7;
        it.rd  = rd_in;
        @(posedge CLK);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pop) q.delete(0);
            if (push) q.push_back(it);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'd7, 32'd1, 5'd1, 1'b1, 3'd1, 7'd0, 5'd3);
        tick(); tick();
        checks++;
        if (dut_out() !== {1'b0, 1'b1, 47'd0}) begin
            errors++;
            $display("FAIL reset: got %h expected %h", dut_out(), {1'b0, 1'b1, 47'd0});
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", dut_out(), model_out());
        end
    endtask

    task automatic test_basic_push();
        out_ready = 1'b0;
        drive(1'b1, 32'd50, 32'd0, 5'd4, 1'b1, 3'b001, 7'd0, 5'd9);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, Rs1, Rs2, funct3_2, funct7_5, En, illegal} !==
            {1'b1, 32'd50, 6'd4, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_push: got v=%b rs1=%0d rs2=%0d f3=%b f7=%b en=%b ill=%b expected 1 50 4 0 0 1 0",
                     out_valid, Rs1, Rs2, funct3_2, funct7_5, En, illegal);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL basic_pop: got %h expected %h", dut_out(), model_out());
        end
    endtask

    task automatic test_full_hold();
        out_ready = 1'b0;
        drive(1'b1, 32'hABCDFFFF, 32'd5, 5'd17, 1'b0, 3'b101, 7'd0, 5'd1);
        tick();
        drive(1'b1, 32'h12345678, 32'd0, 5'd3, 1'b1, 3'b101, 7'b0100000, 5'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_random(1'b1, 1'b1);
            checks++;
            if ({in_ready, out_valid, Rs1, Rs2, rd_out} !== {1'b0, 1'b1, 32'hABCDFFFF, 6'd5, 5'd1}) begin
                errors++;
                $display("FAIL full_hold_A: got rdy=%b v=%b rs1=%h rs2=%0d rd=%0d expected 0 1 abcdffff 5 1",
                         in_ready, out_valid, Rs1, Rs2, rd_out);
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if ({Rs1, Rs2, funct3_2, funct7_5, En, in_ready} !== {32'h12345678, 6'd3, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL full_drain_B: got rs1=%h rs2=%0d f3=%b f7=%b en=%b rdy=%b expected 12345678 3 1 1 1 1",
                     Rs1, Rs2, funct3_2, funct7_5, En, in_ready);
        end
        tick();
        checks++;
        if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL full_drain_empty: got %h expected %h", dut_out(), model_out());
        end
    endtask

    task automatic test_streaming();
        logic [31:0] last_rs1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_random(1'b1, 1'b1);
            last_rs1 = Rs1_in;
            tick();
            checks++;
            if (dut_out() !== model_out() || in_ready !== 1'b1 || Rs1 !== last_rs1) begin
                errors++;
                $display("FAIL stream[%0d]: got %h expected %h (rs1 %h vs %h)",
                         i, dut_out(), model_out(), Rs1, last_rs1);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd2, 5'd2, 1'b0, 3'b001, 7'b0100000, 5'd4);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, En, illegal} !== 3'b101) begin
            errors++;
            $display("FAIL illegal_flag: got v/en/ill=%b expected 101", {out_valid, En, illegal});
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, illegal} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_pop: got v/ill=%b expected 00", {out_valid, illegal});
        end
    endtask

    task automatic test_flush_rst(input logic use_rst);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_random(1'b1, 1'b1);
            tick();
        end
        drive_random(1'b1, 1'b1);
        out_ready = 1'b1;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (dut_out() !== {1'b0, 1'b1, 47'd0}) begin
            errors++;
            $display("FAIL %s_full: got %h expected %h", use_rst ? "rst" : "flush", dut_out(), {1'b0, 1'b1, 47'd0});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_reappear: got out_valid=%b expected 0", use_rst ? "rst" : "flush", out_valid);
        end
    endtask

    task automatic test_shamt_reg();
        out_ready = 1'b0;
        drive(1'b1, 32'd9, 32'hFFFFFFE3, 5'd30, 1'b0, 3'b101, 7'd0, 5'd5);
        tick();
        in_valid = 1'b0;
        checks++;
        if (Rs2 !== 6'b000011) begin
            errors++;
            $display("FAIL shamt_reg: got %b expected 000011", Rs2);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_random(($urandom_range(0, 3) != 0), 1'b0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_out(), model_out());
            end
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 3'd0, 7'd0, 5'd0);
        test_reset();
        test_basic_push();
        test_full_hold();
        test_streaming();
        test_illegal();
        test_flush_rst(1'b0);
        test_flush_rst(1'b1);
        test_shamt_reg();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_shift_stage.md
ID_EX_SHIFT_STAGE -- requirements
Module: id_ex_shift_stage

Interface
REQ-001 Parameter XLEN, default 32, operand datapath width.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream decode has a shift-class instruction.
REQ-005 in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
REQ-006 Rs1_in  input  XLEN  source operand 1.
REQ-007 Rs2_in  input  XLEN  source operand 2, register form.
REQ-008 imm_shamt  input  5  immediate shift amount, immediate form.
REQ-009 use_imm  input  1  1 selects imm_shamt, 0 selects Rs2_in[4:0].
REQ-010 funct3  input  3  instruction funct3.
REQ-011 funct7  input  7  instruction funct7.
REQ-012 rd_in  input  5  destination register index.
REQ-013 flush  input  1  discard all held instructions.
REQ-014 out_valid  output  1  head entry presented to Shift_Unit.
REQ-015 out_ready  input  1  downstream consumes head entry.
REQ-016 Rs1  output  XLEN  operand to Shift_Unit Rs1.
REQ-017 Rs2  output  6  shift amount to Shift_Unit Rs2.
REQ-018 funct3_2  output  1  funct3[2] of head entry.
REQ-019 funct7_5  output  1  funct7[5] of head entry.
REQ-020 En  output  1  Shift_Unit enable.
REQ-021 rd_out  output  5  destination of head entry.
REQ-022 illegal  output  1  head entry is not a legal RV32 shift encoding.

Function
REQ-023 Storage: two entries, MAIN (head) and SKID; states EMPTY, ONE (MAIN only), FULL (MAIN+SKID).
REQ-024 Push = in_valid & in_ready; pop = out_valid & out_ready; out_valid = state != EMPTY.
REQ-025 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, evaluated from next-state at each edge.
REQ-026 EMPTY: push -> MAIN<=input, ONE; else stay.
REQ-027 ONE: push&pop -> MAIN<=input, ONE; push only -> SKID<=input, FULL; pop only -> EMPTY; neither -> hold.
REQ-028 FULL: pop -> MAIN<=SKID, ONE; else hold both; no push possible.
REQ-029 Latency: instruction accepted at edge k appears on outputs with out_valid=1 after edge k (EMPTY case); order strictly FIFO.
REQ-030 Captured shift amount: use_imm ? imm_shamt : Rs2_in[4:0]; Rs2 output = {1'b0, shamt}, bit 5 always 0.
REQ-031 Legal = (funct3==001 & funct7==0000000) | (funct3==101 & funct7==0000000) | (funct3==101 & funct7==0100000); computed at capture and stored.
REQ-032 En = out_valid & legal(MAIN); illegal = out_valid & ~legal(MAIN).
REQ-033 In EMPTY: Rs1=0, Rs2=0, funct3_2=0, funct7_5=0, En=0, rd_out=0, illegal=0.
REQ-034 flush=1 at an edge: next state EMPTY, both entries invalidated, any push that cycle discarded; flush overrides push and pop.
REQ-035 Payload of a held entry SHALL not change while not popped (stable under out_ready=0).

Reset
REQ-036 rst=1 at an edge: state EMPTY, in_ready=1, all outputs per REQ-033; rst overrides flush, push, pop.
REQ-037 rst asserted mid-transfer SHALL drop both entries; no entry reappears after rst deasserts.

Verification
REQ-038 Reset, then push Rs1=50, use_imm=1, imm_shamt=4, funct3=001, funct7=0 -> next cycle out_valid=1, Rs1=50, Rs2=4, funct3_2=0, funct7_5=0, En=1, illegal=0.
REQ-039 out_ready=0, push A (Rs1=32'hABCDFFFF, Rs2_in=5, funct3=101, funct7=0) then B (shamt 3, funct7=0100000) -> FULL, in_ready=0, A held stable; raise out_ready -> A then B, B shows funct3_2=1, funct7_5=1, Rs2=3.
REQ-040 Streaming push and pop every cycle with out_ready=1 for 20 random legal instructions -> in_ready stays 1, outputs match inputs in order one cycle later.
REQ-041 Push funct3=001, funct7=0100000 -> out_valid=1, En=0, illegal=1; pop clears it.
REQ-042 In FULL assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, all outputs 0; repeat with rst=1 mid-stream -> identical result.
REQ-043 Rs2_in=32'hFFFFFFE3, use_imm=0 -> Rs2=6'b000011.
